utimer_arb: RTL and testbench
=============================

Name: utimer_arb

Overview:
- Scheduler that shares one universal 8-bit counter/timer among NREQ requesters.
- Each requester asks for a timeout of N clocks. The block arbitrates, then sequences the counter through preload and count-down, and returns a one-cycle done pulse to the winner.
- Sits between requesting blocks and a single counter instance. It drives the counter's load, direction, preload and wrap/stop controls and observes the counter's count value.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IW, 3, width of the grant index; must satisfy 2^IW >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- _areset  input  1  asynchronous reset, active-low.
- req  input  NREQ  per-requester timeout request, level; held until done or dropped to cancel.
- req_len  input  8*NREQ  timeout length per requester; slice i = bits [8i+7:8i]; sampled only in LOAD.
- done  output  NREQ  one-hot, one-cycle pulse when the granted timeout expires.
- grant  output  NREQ  one-hot, current owner of the counter; 0 when idle.
- grant_idx  output  IW  binary index of the owner; 0 when idle.
- busy  output  1  high in LOAD and RUN.
- ctr_load_n  output  1  to counter: active-low synchronous preload.
- ctr_preld  output  8  to counter: preload value.
- ctr_updown  output  1  to counter: 1 = up, 0 = down.
- ctr_wrapstop  output  1  to counter: wrap/stop select.
- ctr_dcount  input  8  from counter: current count.

Behaviour:
- Counter contract: while ctr_load_n=0, counter = ctr_preld at the next edge; otherwise it steps by ±1 every clock per ctr_updown.
- Reset (_areset=0, asynchronous):
  - state=IDLE; grant=0, grant_idx=0, done=0, busy=0.
  - ctr_load_n=1, ctr_preld=0, ctr_updown=0, ctr_wrapstop=0.
  - Round-robin pointer = 0.
- IDLE:
  - If any req bit is set, pick a winner by round-robin: the first set bit at or after the pointer, wrapping modulo NREQ.
  - Register grant/grant_idx for the winner; go to LOAD.
  - Pointer = winner+1 (mod NREQ), updated at grant.
- LOAD (1 cycle):
  - ctr_load_n=0; ctr_preld = req_len slice of grant_idx; ctr_updown=0.
  - Always go to RUN.
- RUN:
  - ctr_load_n=1, ctr_updown=0.
  - When ctr_dcount==0: done[grant_idx]=1 for exactly this one cycle (registered pulse), grant cleared, go to IDLE.
- Latency: req in IDLE edge k → grant at k+1 → load edge k+2 → done asserted len+2 cycles after grant.
- len=0: done fires in the first RUN cycle. Do not special-case it.
- Cancel: if req[grant_idx] drops in LOAD or RUN:
  - go to IDLE next edge, no done pulse, grant cleared.
  - Pointer is not rolled back.
- New req or changed req_len from other requesters during LOAD/RUN has no effect until IDLE.
- Re-request: the winner may hold req high after done. It re-arbitrates in IDLE the cycle after done and loses to any other pending requester.
- Idle-to-grant needs one IDLE cycle: no back-to-back grant in the done cycle.
- ctr_wrapstop held 0 (stop) always. The counter must never be left counting through wrap while owned.
- Reset mid-RUN: all outputs to reset values immediately; no done.
- Invariants: grant is one-hot or zero; done ⊆ previous-cycle grant; busy = (state != IDLE).

Optional Feature:
- Macro UTIMER_ARB_PRIO_EN.
- Defined: fixed priority; lowest set req index always wins; pointer logic removed.
- Undefined: round-robin as above.

Test Plan:
- Reset: _areset low mid-RUN with len=200 → grant=0, busy=0, ctr_load_n=1, done never pulses. After release, IDLE.
- Single requester: req[1]=1, len=5 → grant=0010 next edge; ctr_load_n low 1 cycle with ctr_preld=5; done[1] pulses exactly 7 cycles after grant; grant=0 next cycle.
- Zero length: req[0]=1, len=0 → done[0] one cycle after LOAD (2 cycles after grant).
- Round-robin fairness: req=1111 held, all len=3 → grants in order 0,1,2,3,0 with one IDLE cycle between; each done 5 cycles after its grant. With UTIMER_ARB_PRIO_EN, grants are 0,0,0,...
- Cancel: req[2]=1, len=50; drop req[2] 10 cycles into RUN → IDLE next edge, no done[2]. req[3] pending → granted next IDLE.
- Late change: while req[0] runs with len=4, change req_len[0] to 99 → done[0] still after 4 counts.

Source files
------------

// File: rtl/utimer_arb_if.sv
// Signal bundle between utimer_arb, its requesters and the shared 8-bit counter.
// Handshake: req is a level held by a requester until its one-cycle done pulse
// (or dropped to cancel); grant shows the current owner and ctr_* drive the counter.
interface utimer_arb_if #(
  parameter int NREQ = 4,
  parameter int IW   = 3
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_len;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              busy;
  logic              ctr_load_n;
  logic [7:0]        ctr_preld;
  logic              ctr_updown;
  logic              ctr_wrapstop;
  logic [7:0]        ctr_dcount;
  logic [1:0]        dbg_state;

  modport master (
    output req, req_len, ctr_dcount,
    input  done, grant, grant_idx, busy, ctr_load_n, ctr_preld,
           ctr_updown, ctr_wrapstop, dbg_state
  );

  modport slave (
    input  req, req_len, ctr_dcount,
    output done, grant, grant_idx, busy, ctr_load_n, ctr_preld,
           ctr_updown, ctr_wrapstop, dbg_state
  );
endinterface

// File: rtl/utimer_arb.sv
// Shares one 8-bit down-counter among NREQ timeout requesters (IDLE/LOAD/RUN).
// Define UTIMER_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module utimer_arb #(
  parameter int NREQ = 4,
  parameter int IW   = 3
) (
  input logic         clk,
  input logic         _areset,
  utimer_arb_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic [IW-1:0]     cand;
  logic [NREQ-1:0]   req_rot;
  logic              owner_req;
  logic [8*NREQ-1:0] len_shift;

`ifdef UTIMER_ARB_PRIO_EN
  // Descending scan: the last hit written is the lowest set index.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    req_rot = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand    = IW'(i);
      req_rot = bus.req >> cand;
      if (req_rot[0]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;

  // Descending scan from pointer: the last hit is the first set bit at/after ptr_q.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    req_rot = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand    = IW'((int'(ptr_q) + i) % NREQ);
      req_rot = bus.req >> cand;
      if (req_rot[0]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && win_vld) begin
      ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  assign owner_req = |(bus.req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_LOAD;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          idx_d   = win_idx;
        end
      end
      S_LOAD: begin
        if (!owner_req) begin
          state_d = S_IDLE;
          grant_d = '0;
          idx_d   = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A cancel in the expiry cycle wins: the requester no longer wants done.
        if (!owner_req) begin
          state_d = S_IDLE;
          grant_d = '0;
          idx_d   = '0;
        end else if (bus.ctr_dcount == 8'd0) begin
          state_d = S_IDLE;
          done_d  = grant_q;
          grant_d = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign len_shift        = bus.req_len >> {idx_q, 3'b000};
  assign bus.ctr_load_n   = (state_q != S_LOAD);
  assign bus.ctr_preld    = (state_q == S_LOAD) ? len_shift[7:0] : 8'd0;
  assign bus.ctr_updown   = 1'b0;
  assign bus.ctr_wrapstop = 1'b0;
  assign bus.grant        = grant_q;
  assign bus.grant_idx    = idx_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_utimer_arb.sv
// Directed bench for utimer_arb with a behavioural model of the shared counter.
module tb_utimer_arb;
  localparam int NREQ = 4;
  localparam int IW   = 3;

  logic clk;
  logic rst_n;
  logic [7:0] cnt;
  logic [NREQ-1:0] grant_prev;
  int n_checks;
  int n_fail;
  int done_total;
  int done2_cnt;
  logic [IW-1:0] exp_q[$];

  utimer_arb_if #(.NREQ(NREQ), .IW(IW)) bus ();

  utimer_arb #(.NREQ(NREQ), .IW(IW)) dut (
    .clk     (clk),
    ._areset (rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counter model: preload when load_n low, else step; stop at 0 when wrapstop=0
  initial cnt = 8'd0;
  always @(posedge clk) begin
    if (!bus.ctr_load_n)                   cnt <= bus.ctr_preld;
    else if (bus.ctr_updown)               cnt <= cnt + 8'd1;
    else if (cnt != 8'd0 || bus.ctr_wrapstop) cnt <= cnt - 8'd1;
  end
  assign bus.ctr_dcount = cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // continuous invariants
  initial grant_prev = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done != '0) begin
        done_total++;
        check("done_in_prev_grant", 32'(bus.done & ~grant_prev), 32'd0);
        check("done_onehot", 32'($onehot(bus.done)), 32'd1);
      end
      if (bus.done[2]) done2_cnt++;
      if (bus.grant != '0) check("grant_onehot", 32'($onehot(bus.grant)), 32'd1);
    end
    grant_prev = bus.grant;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input logic [7:0] v);
    logic [8*NREQ-1:0] tmp;
    tmp = bus.req_len;
    tmp[8*i +: 8] = v;
    bus.req_len = tmp;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.grant == '0 && cyc < 50);
    if (bus.grant == '0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.done == '0 && cyc < 300);
    if (bus.done == '0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int snap;
    logic [IW-1:0] e;
    n_checks = 0;
    n_fail = 0;
    done_total = 0;
    done2_cnt = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_len = '0;
    repeat (3) tick();

    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_load_n", 32'(bus.ctr_load_n), 32'd1);
    check("rst_preld", 32'(bus.ctr_preld), 32'd0);
    check("rst_updown", 32'(bus.ctr_updown), 32'd0);
    check("rst_wrapstop", 32'(bus.ctr_wrapstop), 32'd0);
    rst_n = 1'b1;
    tick();

    // reset asserted mid-RUN with a long timeout
    set_len(0, 8'd200);
    bus.req = 4'b0001;
    repeat (6) tick();
    check("midrun_busy", 32'(bus.busy), 32'd1);
    check("midrun_state", 32'(bus.dbg_state), 32'd2);
    snap = done_total;
    rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(bus.grant), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_load_n", 32'(bus.ctr_load_n), 32'd1);
    check("arst_done", 32'(bus.done), 32'd0);
    bus.req = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("arst_idle", 32'(bus.dbg_state), 32'd0);
    check("arst_no_done", 32'(done_total), 32'(snap));

    // single requester, len=5
    set_len(1, 8'd5);
    bus.req = 4'b0010;
    wait_grant(cyc);
    check("single_grant", 32'(bus.grant), 32'b0010);
    check("single_idx", 32'(bus.grant_idx), 32'd1);
    check("single_busy", 32'(bus.busy), 32'd1);
    check("single_load_n", 32'(bus.ctr_load_n), 32'd0);
    check("single_preld", 32'(bus.ctr_preld), 32'd5);
    check("single_updown", 32'(bus.ctr_updown), 32'd0);
    tick();
    check("single_load_once", 32'(bus.ctr_load_n), 32'd1);
    wait_done(cyc);
    check("single_done_lat", 32'(cyc + 1), 32'd7);
    check("single_done", 32'(bus.done), 32'b0010);
    check("single_grant_clr", 32'(bus.grant), 32'd0);
    bus.req = '0;
    tick();
    check("single_done_width", 32'(bus.done), 32'd0);
    check("single_idle", 32'(bus.busy), 32'd0);

    // zero length
    set_len(0, 8'd0);
    bus.req = 4'b0001;
    wait_grant(cyc);
    check("zero_grant", 32'(bus.grant), 32'b0001);
    wait_done(cyc);
    check("zero_done_lat", 32'(cyc), 32'd2);
    check("zero_done", 32'(bus.done), 32'b0001);
    bus.req = '0;
    tick();

    // fairness: reset pointer, then all requesters held with len=3
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NREQ; i++) set_len(i, 8'd3);
    exp_q = {};
`ifdef UTIMER_ARB_PRIO_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(IW'(0));
`else
    for (int i = 0; i < 5; i++) exp_q.push_back(IW'(i % NREQ));
`endif
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(cyc);
      check("rr_gap", 32'(cyc), 32'd1);
      e = exp_q.pop_front();
      check("rr_grant_idx", 32'(bus.grant_idx), 32'(e));
      check("rr_grant", 32'(bus.grant), 32'(4'b0001 << e));
      wait_done(cyc);
      check("rr_done_lat", 32'(cyc), 32'd5);
      check("rr_done", 32'(bus.done), 32'(4'b0001 << e));
    end
    bus.req = '0;
    tick();
    check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // cancel mid-RUN with another requester pending
    set_len(2, 8'd50);
    set_len(3, 8'd2);
    bus.req = 4'b0100;
    wait_grant(cyc);
    check("cancel_grant", 32'(bus.grant), 32'b0100);
    tick();
    repeat (10) tick();
    snap = done2_cnt;
    bus.req = 4'b1100;
    tick();
    check("cancel_still_owner", 32'(bus.grant), 32'b0100);
    bus.req = 4'b1000;
    tick();
    check("cancel_grant_clr", 32'(bus.grant), 32'd0);
    check("cancel_idle", 32'(bus.busy), 32'd0);
    check("cancel_no_done", 32'(bus.done), 32'd0);
    tick();
    check("cancel_next_grant", 32'(bus.grant), 32'b1000);
    check("cancel_next_idx", 32'(bus.grant_idx), 32'd3);
    wait_done(cyc);
    check("cancel_next_lat", 32'(cyc), 32'd4);
    check("cancel_next_done", 32'(bus.done), 32'b1000);
    check("cancel_no_done2", 32'(done2_cnt), 32'(snap));
    bus.req = '0;
    tick();

    // req_len change after LOAD has no effect
    set_len(0, 8'd4);
    bus.req = 4'b0001;
    wait_grant(cyc);
    check("late_grant", 32'(bus.grant), 32'b0001);
    check("late_preld", 32'(bus.ctr_preld), 32'd4);
    tick();
    set_len(0, 8'd99);
    wait_done(cyc);
    check("late_done_lat", 32'(cyc + 1), 32'd6);
    check("late_done", 32'(bus.done), 32'b0001);
    bus.req = '0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
